// File: rtl/axi_wr_sched_pkg.sv
// Shared definitions for the posted write buffer / read-write scheduler.
package axi_wr_sched_pkg;

    // Request type encoding shared by the write and read sides.
    localparam logic [2:0] REQ_LINE  = 3'b100;
    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_HALF = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    // A line is four 32-bit beats.
    localparam int LINE_BEATS = 4;
    localparam int BEAT_W     = 32;
    localparam int LINE_W     = LINE_BEATS * BEAT_W;

    // Drain FSM: wait for a slot at the bridge, wait for the bridge to take it,
    // wait for the B response.
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY
    } drain_state_t;

    // One queued write.
    typedef struct packed {
        logic [2:0]        typ;
        logic [31:0]       addr;
        logic [3:0]        wstrb;
        logic [LINE_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/wr_sched_fifo.sv
// Circular write queue. The head stays resident until its bridge write has
// completed, so the per-slot valid/tag view also covers the in-flight write.
import axi_wr_sched_pkg::*;

module wr_sched_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  wr_entry_t               push_entry,
    input  logic                    pop,
    output wr_entry_t               head,
    output logic                    full,
    output logic                    empty,
    output logic [DEPTH-1:0]        slot_valid,
    output logic [DEPTH-1:0][27:0]  slot_tag
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    wr_entry_t     mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW-1:0] count;

    // The extra pointer bit distinguishes full from empty.
    assign count = wp - rp;
    assign full  = (count == PW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rp[AW-1:0]];

    // Advance write/read pointers; both may move in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop)  rp <= rp + PW'(1);
        end
    end

    // Entry storage carries no reset; validity comes from the pointers.
    always_ff @(posedge clock) begin
        if (push) mem[wp[AW-1:0]] <= push_entry;
    end

    // A slot is live when its distance from the read pointer is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [AW-1:0] off;
        assign off           = AW'(g) - rp[AW-1:0];
        assign slot_valid[g] = ({1'b0, off} < count);
        assign slot_tag[g]   = mem[g].addr[31:4];
    end

endmodule

// File: rtl/axi_wr_sched.sv
// Posted write buffer between the dcache and the AXI bridge d_* port.
// Writes drain one at a time; reads bypass queued writes unless a queued
// entry (including the one in flight) targets the same 16-byte line.
import axi_wr_sched_pkg::*;

module axi_wr_sched #(
    parameter int DEPTH      = 4,
    parameter int WR_AGE_MAX = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          c_wr_req,
    input  logic [2:0]    c_wr_type,
    input  logic [31:0]   c_wr_addr,
    input  logic [3:0]    c_wr_wstrb,
    input  logic [127:0]  c_wr_data,
    output logic          c_wr_rdy,
    input  logic          c_rd_req,
    input  logic [2:0]    c_rd_type,
    input  logic [31:0]   c_rd_addr,
    output logic          c_rd_rdy,
    output logic          b_wr_req,
    output logic [2:0]    b_wr_type,
    output logic [31:0]   b_wr_addr,
    output logic [3:0]    b_wr_wstrb,
    output logic [127:0]  b_wr_data,
    input  logic          b_wr_rdy,
    output logic          b_rd_req,
    output logic [2:0]    b_rd_type,
    output logic [31:0]   b_rd_addr,
    input  logic          b_rd_rdy,
    output logic          write_buffer_empty
);

    localparam int AGW = $clog2(WR_AGE_MAX + 1);

    wr_entry_t              push_entry;
    wr_entry_t              head;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic                   hazard;
    logic                   rd_pref;
    logic                   issue;
    logic [DEPTH-1:0]       slot_valid;
    logic [DEPTH-1:0][27:0] slot_tag;
    drain_state_t           state;
    logic [AGW-1:0]         age;

    assign push_entry = {c_wr_type, c_wr_addr, c_wr_wstrb, c_wr_data};

    // Acceptance depends only on queue occupancy, never on the bridge.
    assign c_wr_rdy = !full;
    assign push     = c_wr_req && !full;
    assign pop      = (state == S_BUSY) && b_wr_rdy;

    wr_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .slot_valid (slot_valid),
        .slot_tag   (slot_tag)
    );

    // Line-address collision between the pending read and any live entry.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hazard = hazard || (c_rd_req && slot_valid[i] && (slot_tag[i] == c_rd_addr[31:4]));
        end
    end

    // Reads win unless the queue is full or the head has waited too long.
    assign rd_pref  = c_rd_req && !hazard && (age < AGW'(WR_AGE_MAX)) && !full;
    assign b_wr_req = (state == S_IDLE) && !empty && !rd_pref;
    assign issue    = b_wr_req && b_wr_rdy;

    assign b_rd_req  = c_rd_req && !hazard;
    assign c_rd_rdy  = b_rd_rdy && b_rd_req;
    assign b_rd_type = c_rd_type;
    assign b_rd_addr = c_rd_addr;

    assign b_wr_type  = head.typ;
    assign b_wr_addr  = head.addr;
    assign b_wr_wstrb = head.wstrb;
    assign b_wr_data  = head.data;

    assign write_buffer_empty = empty && (state == S_IDLE);

    // Drain FSM: b_wr_rdy low means the bridge took the write, high again means B is done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (issue)     state <= S_ISSUE;
                S_ISSUE: if (!b_wr_rdy) state <= S_BUSY;
                S_BUSY:  if (b_wr_rdy)  state <= S_IDLE;
                default:                state <= S_IDLE;
            endcase
        end
    end

    // Head age: counts idle cycles a pending write is held back, saturates at the limit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            age <= '0;
        end else if (pop) begin
            age <= '0;
        end else if (!empty && (state == S_IDLE) && !issue && (age != AGW'(WR_AGE_MAX))) begin
            age <= age + AGW'(1);
        end
    end

endmodule

// File: tb/tb_axi_wr_sched.sv
`timescale 1ns/1ps
module tb_axi_wr_sched;

    localparam int DEPTH      = 4;
    localparam int WR_AGE_MAX = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         c_wr_req = 1'b0;
    logic [2:0]   c_wr_type = 3'b000;
    logic [31:0]  c_wr_addr = '0;
    logic [3:0]   c_wr_wstrb = '0;
    logic [127:0] c_wr_data = '0;
    logic         c_wr_rdy;
    logic         c_rd_req = 1'b0;
    logic [2:0]   c_rd_type = 3'b000;
    logic [31:0]  c_rd_addr = '0;
    logic         c_rd_rdy;
    logic         b_wr_req;
    logic [2:0]   b_wr_type;
    logic [31:0]  b_wr_addr;
    logic [3:0]   b_wr_wstrb;
    logic [127:0] b_wr_data;
    logic         b_wr_rdy = 1'b1;
    logic         b_rd_req;
    logic [2:0]   b_rd_type;
    logic [31:0]  b_rd_addr;
    logic         b_rd_rdy = 1'b0;
    logic         write_buffer_empty;

    axi_wr_sched #(.DEPTH(DEPTH), .WR_AGE_MAX(WR_AGE_MAX)) dut (
        .clock              (clock),
        .reset              (reset),
        .c_wr_req           (c_wr_req),
        .c_wr_type          (c_wr_type),
        .c_wr_addr          (c_wr_addr),
        .c_wr_wstrb         (c_wr_wstrb),
        .c_wr_data          (c_wr_data),
        .c_wr_rdy           (c_wr_rdy),
        .c_rd_req           (c_rd_req),
        .c_rd_type          (c_rd_type),
        .c_rd_addr          (c_rd_addr),
        .c_rd_rdy           (c_rd_rdy),
        .b_wr_req           (b_wr_req),
        .b_wr_type          (b_wr_type),
        .b_wr_addr          (b_wr_addr),
        .b_wr_wstrb         (b_wr_wstrb),
        .b_wr_data          (b_wr_data),
        .b_wr_rdy           (b_wr_rdy),
        .b_rd_req           (b_rd_req),
        .b_rd_type          (b_rd_type),
        .b_rd_addr          (b_rd_addr),
        .b_rd_rdy           (b_rd_rdy),
        .write_buffer_empty (write_buffer_empty)
    );

    always #5 clock = ~clock;

    // Reference model: queue of pending writes plus the status of the write
    // that has been handed to the bridge.
    typedef struct {
        logic [2:0]   typ;
        logic [31:0]  addr;
        logic [3:0]   wstrb;
        logic [127:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] issued[$];
    bit          inflight    = 0;  // head handed to bridge, B not yet seen
    bit          bridge_left = 0;  // bridge has dropped b_wr_rdy for the head
    int          age         = 0;
    bit          auto_bridge = 0;
    int          bridge_cnt  = 0;
    int          tests = 0;
    int          fails = 0;

    bit e_wr_rdy, e_wr_req, e_rd_req, e_rd_rdy, e_empty;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit line_hit(input logic [31:0] a);
        foreach (q[i]) if (q[i].addr[31:4] == a[31:4]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        inflight    = 0;
        bridge_left = 0;
        age         = 0;
        bridge_cnt  = 0;
    endtask

    task automatic model_expect();
        bit hz;
        bit pref;
        hz       = c_rd_req && line_hit(c_rd_addr);
        pref     = c_rd_req && !hz && (age < WR_AGE_MAX) && (q.size() != DEPTH);
        e_wr_rdy = (q.size() != DEPTH);
        e_wr_req = !inflight && (q.size() != 0) && !pref;
        e_rd_req = c_rd_req && !hz;
        e_rd_rdy = e_rd_req && b_rd_rdy;
        e_empty  = (q.size() == 0) && !inflight;
    endtask

    task automatic model_update();
        bit   push;
        bit   issue;
        bit   pop;
        ent_t e;
        push  = c_wr_req && e_wr_rdy;
        issue = e_wr_req && b_wr_rdy;
        pop   = inflight && bridge_left && b_wr_rdy;
        if (pop) age = 0;
        else if ((q.size() != 0) && !inflight && !issue && (age < WR_AGE_MAX)) age++;
        if (issue) begin
            inflight    = 1;
            bridge_left = 0;
            issued.push_back(q[0].addr);
        end else if (inflight && !bridge_left && !b_wr_rdy) begin
            bridge_left = 1;
            bridge_cnt  = $urandom_range(0, 3);
        end else if (pop) begin
            inflight    = 0;
            bridge_left = 0;
            void'(q.pop_front());
        end else if (bridge_left && bridge_cnt > 0) begin
            bridge_cnt--;
        end
        if (push) begin
            e.typ = c_wr_type; e.addr = c_wr_addr; e.wstrb = c_wr_wstrb; e.data = c_wr_data;
            q.push_back(e);
        end
    endtask

    // One clock cycle: inputs are already driven; compare, clock, advance model.
    task automatic cyc();
        if (auto_bridge) b_wr_rdy = !inflight || (bridge_left && bridge_cnt == 0);
        #1;
        model_expect();
        chk("c_wr_rdy", c_wr_rdy, e_wr_rdy);
        chk("b_wr_req", b_wr_req, e_wr_req);
        chk("b_rd_req", b_rd_req, e_rd_req);
        chk("c_rd_rdy", c_rd_rdy, e_rd_rdy);
        chk("write_buffer_empty", write_buffer_empty, e_empty);
        chk("b_rd_addr", b_rd_addr, c_rd_addr);
        chk("b_rd_type", b_rd_type, c_rd_type);
        if (e_wr_req) begin
            chk("b_wr_addr", b_wr_addr, q[0].addr);
            chk("b_wr_data", b_wr_data, q[0].data);
            chk("b_wr_type", b_wr_type, q[0].typ);
            chk("b_wr_wstrb", b_wr_wstrb, q[0].wstrb);
        end
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        c_wr_req    = 0;
        c_rd_req    = 0;
        auto_bridge = 1;
        while ((q.size() != 0 || inflight) && n < 200) begin
            cyc();
            n++;
        end
        chk("drain_bound", (q.size() == 0 && !inflight), 1'b1);
        chk("drain_wbe", write_buffer_empty, 1'b1);
        auto_bridge = 0;
        b_wr_rdy    = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d_line;
        int           hold;
        bit           seen;
        logic [31:0]  exp_order[$];

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        chk("rst_c_wr_rdy", c_wr_rdy, 1'b1);
        chk("rst_b_wr_req", b_wr_req, 1'b0);
        chk("rst_b_rd_req", b_rd_req, 1'b0);
        chk("rst_c_rd_rdy", c_rd_rdy, 1'b0);
        chk("rst_wbe", write_buffer_empty, 1'b1);
        reset = 0;
        model_reset();

        // Single line write
        d_line     = {$urandom, $urandom, $urandom, $urandom};
        b_wr_rdy   = 1;
        c_wr_req   = 1; c_wr_type = 3'b100; c_wr_addr = 32'h1000_0040;
        c_wr_wstrb = 4'hf; c_wr_data = d_line;
        #1 chk("line_accept", c_wr_rdy, 1'b1);
        cyc();
        c_wr_req = 0;
        #1;
        chk("line_b_wr_req", b_wr_req, 1'b1);
        chk("line_b_addr", b_wr_addr, 32'h1000_0040);
        chk("line_b_data", b_wr_data, d_line);
        chk("line_wbe_queued", write_buffer_empty, 1'b0);
        cyc();
        cyc();
        b_wr_rdy = 0;
        repeat (3) cyc();
        #1 chk("line_wbe_busy", write_buffer_empty, 1'b0);
        b_wr_rdy = 1;
        cyc();
        #1 chk("line_wbe_done", write_buffer_empty, 1'b1);

        // Fill to DEPTH with no drain, stall the 5th until after the first pop
        issued.delete();
        b_wr_rdy = 0; c_wr_req = 1; c_wr_type = 3'b010; c_wr_wstrb = 4'h3;
        for (int i = 0; i < 4; i++) begin
            c_wr_addr = 32'h5000_0000 + 32'(i * 16);
            c_wr_data = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end
        c_wr_addr = 32'h5000_0040;
        #1 chk("fill_full", c_wr_rdy, 1'b0);
        cyc();
        b_wr_rdy = 1; cyc();
        b_wr_rdy = 0; cyc(); cyc();
        b_wr_rdy = 1;
        #1 chk("fill_pop_cycle_rdy", c_wr_rdy, 1'b0);
        cyc();
        b_wr_rdy = 0;
        #1 chk("fill_after_pop_rdy", c_wr_rdy, 1'b1);
        cyc();
        c_wr_req = 0;
        #1 chk("fill_full_again", c_wr_rdy, 1'b0);
        drain();
        chk("fill_issue_count", issued.size(), 5);
        for (int i = 0; i < 5 && i < issued.size(); i++)
            chk("fill_order", issued[i], 32'h5000_0000 + 32'(i * 16));

        // Read hazard against a queued write, then a non-colliding read
        b_wr_rdy = 0; c_wr_req = 1; c_wr_addr = 32'h2000_0010; cyc(); c_wr_req = 0;
        c_rd_req = 1; c_rd_type = 3'b100; c_rd_addr = 32'h2000_001C; b_rd_rdy = 1;
        #1;
        chk("haz_blocked", b_rd_req, 1'b0);
        chk("haz_c_rd_rdy", c_rd_rdy, 1'b0);
        chk("haz_write_goes", b_wr_req, 1'b1);
        cyc();
        b_wr_rdy = 1; cyc();
        b_wr_rdy = 0; cyc(); cyc();
        #1 chk("haz_inflight_blocked", b_rd_req, 1'b0);
        b_wr_rdy = 1; cyc();
        #1;
        chk("haz_released", b_rd_req, 1'b1);
        chk("haz_released_rdy", c_rd_rdy, 1'b1);
        cyc();
        c_rd_req = 0; b_wr_rdy = 0; c_wr_req = 1; c_wr_addr = 32'h2000_0010; cyc(); c_wr_req = 0;
        c_rd_req = 1; c_rd_addr = 32'h2000_0020;
        #1;
        chk("nohaz_issue", b_rd_req, 1'b1);
        chk("nohaz_wr_held", b_wr_req, 1'b0);
        cyc();
        drain();

        // Aging: continuous non-hazard reads hold one write for WR_AGE_MAX cycles
        b_wr_rdy = 1; b_rd_rdy = 1;
        c_wr_req = 1; c_wr_addr = 32'h4000_0000;
        c_rd_req = 1; c_rd_addr = 32'h3000_0000;
        cyc();
        c_wr_req = 0;
        hold = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (b_wr_req) seen = 1;
            else begin hold++; cyc(); end
        end
        chk("age_hold_cycles", hold, WR_AGE_MAX);
        chk("age_wr_req", b_wr_req, 1'b1);
        chk("age_rd_still", b_rd_req, 1'b1);
        cyc();
        drain();

        // Asynchronous reset while busy with 3 entries
        b_wr_rdy = 1; c_wr_req = 1;
        for (int i = 0; i < 3; i++) begin
            c_wr_addr = 32'h6000_0000 + 32'(i * 16);
            cyc();
        end
        c_wr_req = 0; b_wr_rdy = 0;
        cyc(); cyc();
        #1 chk("busy_wbe", write_buffer_empty, 1'b0);
        #1 reset = 1;
        #1;
        chk("arst_wbe", write_buffer_empty, 1'b1);
        chk("arst_c_wr_rdy", c_wr_rdy, 1'b1);
        chk("arst_b_wr_req", b_wr_req, 1'b0);
        model_reset();
        @(posedge clock);
        #1 reset = 0;
        b_wr_rdy = 1;

        // Enqueue during pop at count 2, order kept across pointer wrap
        issued.delete();
        exp_order = '{32'h8000_0000, 32'h8000_0010, 32'h8000_0020, 32'h8000_0030, 32'h8000_0040};
        b_wr_rdy = 0; c_wr_req = 1;
        c_wr_addr = exp_order[0]; cyc();
        c_wr_addr = exp_order[1]; cyc();
        c_wr_req = 0;
        b_wr_rdy = 1; cyc();
        b_wr_rdy = 0; cyc();
        b_wr_rdy = 1; c_wr_req = 1; c_wr_addr = exp_order[2];
        #1 chk("wrap_pop_push_rdy", c_wr_rdy, 1'b1);
        cyc();
        b_wr_rdy = 0;
        c_wr_addr = exp_order[3]; cyc();
        c_wr_addr = exp_order[4];
        #1 chk("wrap_count_two_left", c_wr_rdy, 1'b1);
        cyc();
        c_wr_req = 0;
        #1 chk("wrap_count_full", c_wr_rdy, 1'b0);
        drain();
        chk("wrap_issue_count", issued.size(), 5);
        for (int i = 0; i < 5 && i < issued.size(); i++)
            chk("wrap_order", issued[i], exp_order[i]);

        // Randomized traffic against the model
        auto_bridge = 1;
        bridge_cnt  = 0;
        for (int i = 0; i < 600; i++) begin
            c_wr_req   = ($urandom_range(0, 99) < 35);
            c_wr_type  = ($urandom_range(0, 1) != 0) ? 3'b100 : 3'($urandom_range(0, 2));
            c_wr_addr  = {28'h7000000 + 28'($urandom_range(0, 5)), 4'($urandom_range(0, 15))};
            c_wr_wstrb = 4'($urandom_range(0, 15));
            c_wr_data  = {$urandom, $urandom, $urandom, $urandom};
            c_rd_req   = ($urandom_range(0, 99) < 50);
            c_rd_type  = 3'($urandom_range(0, 4));
            c_rd_addr  = {28'h7000000 + 28'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            b_rd_rdy   = ($urandom_range(0, 1) != 0);
            cyc();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
